// File: rtl/noc_params.sv
// NoC-wide constants and flit format shared by network interfaces and routers.
package noc_params;

    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int FLIT_X_W          = 2;
    localparam int FLIT_Y_W          = 2;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - FLIT_X_W - FLIT_Y_W;

    typedef enum logic [2:0] {
        HEAD     = 3'd0,
        BODY     = 3'd1,
        TAIL     = 3'd2,
        HEADTAIL = 3'd3
    } flit_label_t;

    // Head flits spend part of the payload field on the destination coordinates.
    typedef struct packed {
        flit_label_t              flit_label;
        logic [VC_SIZE-1:0]       vc_id;
        union packed {
            struct packed {
                logic [FLIT_X_W-1:0]          x_dest;
                logic [FLIT_Y_W-1:0]          y_dest;
                logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
            } head_data;
            logic [FLIT_DATA_SIZE-1:0] bt_pl;
        } data;
    } flit_t;

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker for one virtual channel.
module credit_counter #(
    parameter int  BUFFER_SIZE = 8,
    localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             avail_o,
    output logic             err_o
);

    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             full;

    assign full = (count_q == CNT_W'(BUFFER_SIZE));

    // A returned credit on a full counter means the downstream over-reported space.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= CNT_W'(BUFFER_SIZE);
            err_q   <= 1'b0;
        end else begin
            err_q <= inc_i && !dec_i && full;
            case ({inc_i, dec_i})
                2'b10:   if (!full) count_q <= count_q + CNT_W'(1);
                2'b01:   if (count_q != '0) count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign avail_o = (count_q != '0);
    assign err_o   = err_q;

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a packet request plus payload words into
// HEAD/BODY/TAIL flits for the router local port, gated by per-VC credits.
module ni_packetizer
    import noc_params::*;
#(
    parameter int  MESH_SIZE_X      = 4,
    parameter int  MESH_SIZE_Y      = 4,
    parameter int  BUFFER_SIZE      = 8,
    parameter int  MAX_PKT_LEN      = 8,
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y),
    localparam int LEN_W            = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] req_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] req_y_dest_i,
    input  logic [VC_SIZE-1:0]          req_vc_i,
    input  logic [LEN_W-1:0]            req_len_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   data_i,
    output flit_t                       flit_o,
    output logic                        flit_valid_o,
    input  logic                        credit_valid_i,
    input  logic [VC_SIZE-1:0]          credit_vc_i,
    output logic                        busy_o,
    output logic                        credit_err_o,
    output logic [1:0]                  state_dbg_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    // Handshakes: a request transfers on a cycle where req_valid_i and
    // req_ready_o are both high; a payload word transfers (and its flit is
    // sent) on a cycle where data_valid_i and data_ready_o are both high.
    state_t                      state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [VC_SIZE-1:0]          vc_q;
    logic [LEN_W-1:0]            len_q, cnt_q, cnt_next;
    logic                        send, last;
    flit_t                       flit_d, flit_q;
    logic                        flit_valid_q;

    logic [VC_NUM-1:0]            has_credit, inc, dec, err;
    logic [VC_NUM-1:0][CNT_W-1:0] credit_cnt;

    // The flit being sent is the last one when it brings the count up to len.
    assign cnt_next = cnt_q + LEN_W'(1);
    assign last     = (cnt_next == len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i) state_d = S_HEAD;
            S_HEAD:  if (send) state_d = last ? S_IDLE : S_BODY;
            S_BODY:  if (send && last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        busy_o       = (state_q != S_IDLE);
        send         = (state_q != S_IDLE) && data_valid_i && has_credit[vc_q];
        data_ready_o = send;
        flit_d       = '0;
        flit_d.vc_id = vc_q;
        if (state_q == S_HEAD) begin
            flit_d.flit_label             = last ? HEADTAIL : HEAD;
            flit_d.data.head_data.x_dest  = FLIT_X_W'(x_q);
            flit_d.data.head_data.y_dest  = FLIT_Y_W'(y_q);
            flit_d.data.head_data.head_pl = data_i[HEAD_PAYLOAD_SIZE-1:0];
        end else begin
            flit_d.flit_label  = last ? TAIL : BODY;
            flit_d.data.bt_pl  = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            vc_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            flit_valid_q <= send;
            if (send) begin
                flit_q <= flit_d;
                cnt_q  <= cnt_next;
            end
            if (req_valid_i && req_ready_o) begin
                x_q   <= req_x_dest_i;
                y_q   <= req_y_dest_i;
                vc_q  <= req_vc_i;
                len_q <= (req_len_i == '0) ? LEN_W'(1) : req_len_i;
                cnt_q <= '0;
            end
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign dec[v] = send && (vc_q == VC_SIZE'(v));
        assign inc[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v));

        credit_counter #(.BUFFER_SIZE(BUFFER_SIZE)) u_credit (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (inc[v]),
            .dec_i   (dec[v]),
            .count_o (credit_cnt[v]),
            .avail_o (has_credit[v]),
            .err_o   (err[v])
        );
    end

    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;
    assign credit_err_o = |err;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: flit sequencing, stalls, credits and reset.
module tb_ni_packetizer;
    import noc_params::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      req_valid_i = 1'b0;
    logic                      req_ready_o;
    logic [1:0]                req_x_dest_i = '0;
    logic [1:0]                req_y_dest_i = '0;
    logic [VC_SIZE-1:0]        req_vc_i = '0;
    logic [3:0]                req_len_i = '0;
    logic                      data_valid_i = 1'b0;
    logic                      data_ready_o;
    logic [FLIT_DATA_SIZE-1:0] data_i = '0;
    flit_t                     flit_o;
    logic                      flit_valid_o;
    logic                      credit_valid_i = 1'b0;
    logic [VC_SIZE-1:0]        credit_vc_i = '0;
    logic                      busy_o;
    logic                      credit_err_o;
    logic [1:0]                state_dbg_o;

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    busy_cnt = 0;
    int    stall_bad = 0;
    int    c1 = 0;
    int    c2 = 0;
    flit_t got_q[$];
    int    stamp_q[$];

    ni_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_x_dest_i   (req_x_dest_i),
        .req_y_dest_i   (req_y_dest_i),
        .req_vc_i       (req_vc_i),
        .req_len_i      (req_len_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .data_i         (data_i),
        .flit_o         (flit_o),
        .flit_valid_o   (flit_valid_o),
        .credit_valid_i (credit_valid_i),
        .credit_vc_i    (credit_vc_i),
        .busy_o         (busy_o),
        .credit_err_o   (credit_err_o),
        .state_dbg_o    (state_dbg_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flit_valid_o) begin
            got_q.push_back(flit_o);
            stamp_q.push_back(cyc);
        end
        if (busy_o) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic flit_t mk_head(flit_label_t l, int vc, int x, int y, logic [15:0] d);
        flit_t f;
        f = '0;
        f.flit_label = l;
        f.vc_id = VC_SIZE'(vc);
        f.data.head_data.x_dest = FLIT_X_W'(x);
        f.data.head_data.y_dest = FLIT_Y_W'(y);
        f.data.head_data.head_pl = d[HEAD_PAYLOAD_SIZE-1:0];
        return f;
    endfunction

    function automatic flit_t mk_bt(flit_label_t l, int vc, logic [15:0] d);
        flit_t f;
        f = '0;
        f.flit_label = l;
        f.vc_id = VC_SIZE'(vc);
        f.data.bt_pl = d;
        return f;
    endfunction

    function automatic flit_label_t exp_label(int i, int n);
        if (i == 0) return (n == 1) ? HEADTAIL : HEAD;
        return (i == n - 1) ? TAIL : BODY;
    endfunction

    task automatic clear_q();
        got_q.delete();
        stamp_q.delete();
    endtask

    task automatic request(input int x, input int y, input int vc, input int len);
        int t;
        req_valid_i  = 1'b1;
        req_x_dest_i = 2'(x);
        req_y_dest_i = 2'(y);
        req_vc_i     = VC_SIZE'(vc);
        req_len_i    = 4'(len);
        t = 0;
        while (!req_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("req_timeout", 1, 0);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Presents n payload words; optionally one idle cycle before word gap_at and
    // a credit on cvc in every cycle a word is taken.
    task automatic feed(input logic [15:0] base, input int n, input int gap_at,
                        input bit credit_on_send, input int cvc);
        int t;
        for (int i = 0; i < n; i++) begin
            if (credit_on_send) credit_valid_i = 1'b0;
            if (i == gap_at) begin
                data_valid_i = 1'b0;
                @(negedge clk);
            end
            data_valid_i = 1'b1;
            data_i = base + 16'(i);
            t = 0;
            #1;
            while (!data_ready_o && t < 100) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 100) begin
                check("feed_timeout", 1, 0);
                break;
            end
            if (credit_on_send) begin
                credit_valid_i = 1'b1;
                credit_vc_i = VC_SIZE'(cvc);
            end
            @(negedge clk);
        end
        data_valid_i = 1'b0;
        if (credit_on_send) credit_valid_i = 1'b0;
    endtask

    task automatic give_credit(input int vc);
        credit_valid_i = 1'b1;
        credit_vc_i = VC_SIZE'(vc);
        @(negedge clk);
        credit_valid_i = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input int vc, input int x, input int y,
                             input logic [15:0] base, input int n);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            if (i == 0) check({tag, "_head"}, got_q[0], mk_head(exp_label(0, n), vc, x, y, base));
            else        check({tag, "_flit"}, got_q[i], mk_bt(exp_label(i, n), vc, base + 16'(i)));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_flit_valid", flit_valid_o, 0);
        check("rst_flit", flit_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_credit_err", credit_err_o, 0);
        check("rst_data_ready", data_ready_o, 0);
        check("rst_cnt0", dut.credit_cnt[0], 8);
        check("rst_cnt1", dut.credit_cnt[1], 8);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_state", state_dbg_o, 0);

        // Single-flit packet
        clear_q();
        busy_cnt = 0;
        request(3, 1, 0, 1);
        feed(16'h00A5, 1, -1, 0, 0);
        repeat (2) @(negedge clk);
        check_pkt("single", 0, 3, 1, 16'h00A5, 1);
        check("single_busy_cycles", busy_cnt, 1);
        check("single_cnt0", dut.credit_cnt[0], 7);

        // Four flits back to back
        clear_q();
        request(1, 2, 1, 4);
        feed(16'h0100, 4, -1, 0, 0);
        @(negedge clk);
        check_pkt("len4", 1, 1, 2, 16'h0100, 4);
        for (int i = 1; i < 4 && i < stamp_q.size(); i++)
            check("len4_spacing", stamp_q[i] - stamp_q[0], i);
        check("len4_req_ready", req_ready_o, 1);
        check("len4_cnt1", dut.credit_cnt[1], 4);

        // Credit refill, then overflow on a full VC
        give_credit(0);
        check("refill_cnt0", dut.credit_cnt[0], 8);
        give_credit(0);
        check("overflow_err", credit_err_o, 1);
        check("overflow_cnt0", dut.credit_cnt[0], 8);
        @(negedge clk);
        check("overflow_err_clear", credit_err_o, 0);

        // Credit returned in the same cycle as each send on VC 1
        clear_q();
        request(2, 3, 1, 2);
        feed(16'h0300, 2, -1, 1, 1);
        @(negedge clk);
        check_pkt("simul", 1, 2, 3, 16'h0300, 2);
        check("simul_cnt1", dut.credit_cnt[1], 4);
        check("simul_no_err", credit_err_o, 0);
        repeat (4) give_credit(1);
        check("refill_cnt1", dut.credit_cnt[1], 8);

        // Exhaust VC 0 then stall the next packet until credits return
        clear_q();
        request(0, 0, 0, 8);
        feed(16'h0400, 8, -1, 0, 0);
        @(negedge clk);
        check_pkt("len8", 0, 0, 0, 16'h0400, 8);
        check("len8_cnt0", dut.credit_cnt[0], 0);
        clear_q();
        stall_bad = 0;
        request(0, 3, 0, 2);
        fork
            feed(16'h0500, 2, -1, 0, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    #2;
                    if (flit_valid_o || data_ready_o) stall_bad++;
                end
                credit_valid_i = 1'b1;
                credit_vc_i = 1'b0;
                c1 = cyc;
                @(negedge clk);
                credit_valid_i = 1'b0;
                repeat (3) @(negedge clk);
                credit_valid_i = 1'b1;
                c2 = cyc;
                @(negedge clk);
                credit_valid_i = 1'b0;
            end
        join
        @(negedge clk);
        check("stall_quiet", stall_bad, 0);
        check_pkt("stall", 0, 0, 3, 16'h0500, 2);
        if (stamp_q.size() == 2) begin
            check("stall_head_time", stamp_q[0], c1 + 2);
            check("stall_tail_time", stamp_q[1], c2 + 2);
        end
        repeat (8) give_credit(0);
        check("stall_refill_cnt0", dut.credit_cnt[0], 8);

        // Data gap inside a packet
        clear_q();
        request(1, 1, 0, 3);
        feed(16'h0600, 3, 1, 0, 0);
        @(negedge clk);
        check_pkt("gap", 0, 1, 1, 16'h0600, 3);
        if (stamp_q.size() == 3) begin
            check("gap_hole", stamp_q[1] - stamp_q[0], 2);
            check("gap_resume", stamp_q[2] - stamp_q[1], 1);
        end

        // Reset after the head of a five-flit packet
        clear_q();
        request(2, 2, 1, 5);
        feed(16'h0700, 1, -1, 0, 0);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_flit_valid", flit_valid_o, 0);
        check("mid_rst_flit", flit_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_data_ready", data_ready_o, 0);
        check("mid_rst_state", state_dbg_o, 0);
        check("mid_rst_cnt0", dut.credit_cnt[0], 8);
        check("mid_rst_cnt1", dut.credit_cnt[1], 8);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_tail", got_q.size(), 1);
        clear_q();
        request(3, 0, 1, 2);
        feed(16'h0800, 2, -1, 0, 0);
        @(negedge clk);
        check_pkt("after_rst", 1, 3, 0, 16'h0800, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
